control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The parameter NUM_STEPS SHALL have default 5 and SHALL set the microsteps per instruction, legal range 5..8.
REQ-002 Port clk SHALL be an input, 1 bit, the single system clock; all state changes on its rising edge.
REQ-003 Port rst SHALL be an input, 1 bit, the reset; it is asynchronous and active-low.
REQ-004 Port opcode SHALL be an input, 4 bits, the upper nibble of the instruction register.
REQ-005 Ports carry_flag and zero_flag SHALL be inputs, 1 bit each, from the flags register.
REQ-006 Ports pc_out, pc_inc and pc_jump SHALL be outputs, 1 bit each, driving the program counter's out, inc and jump controls.
REQ-007 Ports mar_in, ram_in, ram_out, ir_in, ir_out, a_in, a_out, b_in, alu_out, sub, flags_in and out_in SHALL be outputs, 1 bit each, as the load or drive strobes of the named units.
REQ-008 Port halt SHALL be an output, 1 bit, high while the CPU is halted.
REQ-009 Port step SHALL be an output, 3 bits, the current microstep index for debug.

Function
REQ-010 The block SHALL hold a 3-bit step counter and a 1-bit halted flag as its only state.
REQ-011 Outputs other than step and halt SHALL be combinational decodes of step, opcode, carry_flag and zero_flag.
REQ-012 When not halted, step SHALL advance by 1 each clock and wrap from NUM_STEPS-1 to 0.
REQ-013 In step 0, the block SHALL assert pc_out and mar_in (fetch address).
REQ-014 In step 1, the block SHALL assert ram_out, ir_in and pc_inc (fetch instruction, advance PC).
REQ-015 Execute steps SHALL decode opcode as follows; any strobe not listed is 0.
- 0000 NOP: none.
- 0001 LDA: s2 ir_out,mar_in; s3 ram_out,a_in.
- 0010 ADD: s2 ir_out,mar_in; s3 ram_out,b_in; s4 alu_out,a_in,flags_in.
- 0011 SUB: as ADD, with sub also high in s4.
- 0100 STA: s2 ir_out,mar_in; s3 a_out,ram_in.
- 0101 LDI: s2 ir_out,a_in.
- 0110 JMP: s2 ir_out,pc_jump.
- 0111 JC: s2 ir_out; pc_jump only if carry_flag=1.
- 1000 JZ: s2 ir_out; pc_jump only if zero_flag=1.
- 1110 OUT: s2 a_out,out_in.
- 1111 HLT: s2 sets halted at the next edge.
- other: treated as NOP.
REQ-016 Steps 5..NUM_STEPS-1 SHALL assert no strobes.
REQ-017 At most one bus driver (pc_out, ram_out, ir_out, a_out, alu_out) SHALL be high in any cycle.
REQ-018 A not-taken JC or JZ SHALL assert only ir_out in s2; the PC keeps its incremented value.
REQ-019 When halted=1, the following SHALL hold until reset:
- step frozen at 3;
- all strobes 0;
- halt=1.
REQ-020 Flag inputs SHALL be sampled only combinationally in s2 of JC or JZ, with no internal latching.

Reset
REQ-021 When rst=0, step SHALL be 0 and halted SHALL be 0 immediately, independent of clk.
REQ-022 During reset, step 0 strobes (pc_out, mar_in) SHALL be visible and all others SHALL be 0.
REQ-023 Reset asserted mid-instruction or while halted SHALL abort the instruction with no further strobes.
REQ-024 The first rising edge after rst returns to 1 SHALL move step from 0 to 1.

Verification
REQ-025 Release reset with opcode=0000 and clock 10 cycles: step SHALL read 0,1,2,3,4,0,1,...; only s0 and s1 strobes fire; pc_inc SHALL be high exactly once per 5 cycles.
REQ-026 Apply opcode=0011: s4 SHALL show alu_out=1, a_in=1, flags_in=1, sub=1; s3 SHALL show ram_out=1, b_in=1.
REQ-027 Apply JC with carry_flag=0 then carry_flag=1: pc_jump SHALL be 0 then 1 in s2, and ir_out SHALL be 1 both times.
REQ-028 Apply opcode=1111: from the edge after s2, halt=1 and step=3 SHALL persist for 20 cycles with all strobes 0; rst=0 SHALL clear halt and step to 0.
REQ-029 Pulse rst low mid-cycle during s3 of LDA: step SHALL be 0 without a clock edge, and a_in SHALL drop to 0 immediately.
REQ-030 Drive random opcode and flag values for 1000 cycles: at most one bus driver SHALL be high per cycle, and all strobes SHALL be 0 in s5..NUM_STEPS-1.

Source files
------------

// File: rtl/control_sequencer.sv
// Microcoded control sequencer for a small 8-bit bus CPU: a step counter plus a halt
// flag, with every control strobe decoded combinationally from step, opcode and flags.
module control_sequencer #(
    parameter int NUM_STEPS = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] opcode,
    input  logic       carry_flag,
    input  logic       zero_flag,
    output logic       pc_out,
    output logic       pc_inc,
    output logic       pc_jump,
    output logic       mar_in,
    output logic       ram_in,
    output logic       ram_out,
    output logic       ir_in,
    output logic       ir_out,
    output logic       a_in,
    output logic       a_out,
    output logic       b_in,
    output logic       alu_out,
    output logic       sub,
    output logic       flags_in,
    output logic       out_in,
    output logic       halt,
    output logic [2:0] step
);

    typedef enum logic [3:0] {
        OP_NOP = 4'b0000,
        OP_LDA = 4'b0001,
        OP_ADD = 4'b0010,
        OP_SUB = 4'b0011,
        OP_STA = 4'b0100,
        OP_LDI = 4'b0101,
        OP_JMP = 4'b0110,
        OP_JC  = 4'b0111,
        OP_JZ  = 4'b1000,
        OP_OUT = 4'b1110,
        OP_HLT = 4'b1111
    } opcode_e;

    localparam logic [2:0] LAST_STEP = 3'(NUM_STEPS - 1);

    logic [2:0] r_step;
    logic       r_halted;

    // Halting lands on step 3 because the counter still advances on the HLT edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_step   <= 3'd0;
            r_halted <= 1'b0;
        end else if (!r_halted) begin
            if (r_step == 3'd2 && opcode == OP_HLT)
                r_halted <= 1'b1;
            r_step <= (r_step == LAST_STEP) ? 3'd0 : r_step + 3'd1;
        end
    end

    assign step = r_step;
    assign halt = r_halted;

    always_comb begin
        pc_out   = 1'b0;
        pc_inc   = 1'b0;
        pc_jump  = 1'b0;
        mar_in   = 1'b0;
        ram_in   = 1'b0;
        ram_out  = 1'b0;
        ir_in    = 1'b0;
        ir_out   = 1'b0;
        a_in     = 1'b0;
        a_out    = 1'b0;
        b_in     = 1'b0;
        alu_out  = 1'b0;
        sub      = 1'b0;
        flags_in = 1'b0;
        out_in   = 1'b0;
        if (!r_halted) begin
            case (r_step)
                3'd0: begin
                    pc_out = 1'b1;
                    mar_in = 1'b1;
                end
                3'd1: begin
                    ram_out = 1'b1;
                    ir_in   = 1'b1;
                    pc_inc  = 1'b1;
                end
                3'd2: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            ir_out = 1'b1;
                            mar_in = 1'b1;
                        end
                        OP_LDI: begin
                            ir_out = 1'b1;
                            a_in   = 1'b1;
                        end
                        OP_JMP: begin
                            ir_out  = 1'b1;
                            pc_jump = 1'b1;
                        end
                        // Flags are looked at only here, straight from the inputs.
                        OP_JC: begin
                            ir_out  = 1'b1;
                            pc_jump = carry_flag;
                        end
                        OP_JZ: begin
                            ir_out  = 1'b1;
                            pc_jump = zero_flag;
                        end
                        OP_OUT: begin
                            a_out  = 1'b1;
                            out_in = 1'b1;
                        end
                        default: ;
                    endcase
                end
                3'd3: begin
                    case (opcode)
                        OP_LDA: begin
                            ram_out = 1'b1;
                            a_in    = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            ram_out = 1'b1;
                            b_in    = 1'b1;
                        end
                        OP_STA: begin
                            a_out  = 1'b1;
                            ram_in = 1'b1;
                        end
                        default: ;
                    endcase
                end
                3'd4: begin
                    if (opcode == OP_ADD || opcode == OP_SUB) begin
                        alu_out  = 1'b1;
                        a_in     = 1'b1;
                        flags_in = 1'b1;
                        sub      = (opcode == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed and randomised checks of the control sequencer with default NUM_STEPS=5.
module tb_control_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] opcode;
    logic       carry_flag, zero_flag;
    logic       pc_out, pc_inc, pc_jump, mar_in, ram_in, ram_out, ir_in, ir_out;
    logic       a_in, a_out, b_in, alu_out, sub, flags_in, out_in, halt;
    logic [2:0] step;

    int n_cmp = 0;
    int n_bad = 0;

    control_sequencer dut (
        .clk(clk), .rst(rst), .opcode(opcode), .carry_flag(carry_flag), .zero_flag(zero_flag),
        .pc_out(pc_out), .pc_inc(pc_inc), .pc_jump(pc_jump), .mar_in(mar_in),
        .ram_in(ram_in), .ram_out(ram_out), .ir_in(ir_in), .ir_out(ir_out),
        .a_in(a_in), .a_out(a_out), .b_in(b_in), .alu_out(alu_out), .sub(sub),
        .flags_in(flags_in), .out_in(out_in), .halt(halt), .step(step)
    );

    always #5 clk = ~clk;

    // Strobe vector bit masks
    localparam logic [14:0] PCO = 15'h4000, PCI = 15'h2000, PCJ = 15'h1000, MARI = 15'h0800;
    localparam logic [14:0] RAMI = 15'h0400, RAMO = 15'h0200, IRI = 15'h0100, IRO = 15'h0080;
    localparam logic [14:0] AIN = 15'h0040, AO = 15'h0020, BIN = 15'h0010, ALUO = 15'h0008;
    localparam logic [14:0] SUBM = 15'h0004, FLG = 15'h0002, OUTI = 15'h0001;

    logic [14:0] strb;
    assign strb = {pc_out, pc_inc, pc_jump, mar_in, ram_in, ram_out, ir_in, ir_out,
                   a_in, a_out, b_in, alu_out, sub, flags_in, out_in};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    // Runs one full instruction starting from step 0, ending back at step 0.
    task automatic run_instr(input string nm, input logic [3:0] op, input logic c, input logic z,
                             input logic [14:0] e2, input logic [14:0] e3, input logic [14:0] e4);
        opcode = op; carry_flag = c; zero_flag = z;
        #1;
        chk({nm, "_s0"}, {17'd0, step, strb}, {17'd0, 3'd0, PCO | MARI});
        nxt();
        chk({nm, "_s1"}, {17'd0, step, strb}, {17'd0, 3'd1, RAMO | IRI | PCI});
        nxt();
        chk({nm, "_s2"}, {17'd0, step, strb}, {17'd0, 3'd2, e2});
        nxt();
        chk({nm, "_s3"}, {17'd0, step, strb}, {17'd0, 3'd3, e3});
        nxt();
        chk({nm, "_s4"}, {17'd0, step, strb}, {17'd0, 3'd4, e4});
        nxt();
        chk({nm, "_halt"}, {31'd0, halt}, 32'd0);
    endtask

    int pcinc_cnt;
    int exp_step;
    int nbus;

    initial begin
        rst = 1'b0; opcode = 4'h0; carry_flag = 1'b0; zero_flag = 1'b0;
        #2;
        chk("rst_step", {29'd0, step}, 32'd0);
        chk("rst_halt", {31'd0, halt}, 32'd0);
        chk("rst_strb", {17'd0, strb}, {17'd0, PCO | MARI});
        nxt();
        chk("rst_hold_step", {29'd0, step}, 32'd0);

        // NOP stream: step walks 0..4 and wraps, only fetch strobes fire
        @(negedge clk);
        rst = 1'b1;
        #1;
        pcinc_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            chk("nop_step", {29'd0, step}, 32'(i % 5));
            case (i % 5)
                0:       chk("nop_strb", {17'd0, strb}, {17'd0, PCO | MARI});
                1:       chk("nop_strb", {17'd0, strb}, {17'd0, RAMO | IRI | PCI});
                default: chk("nop_strb", {17'd0, strb}, 32'd0);
            endcase
            pcinc_cnt += int'(pc_inc);
            nxt();
        end
        chk("nop_pcinc_cnt", 32'(pcinc_cnt), 32'd2);

        run_instr("sub",  4'b0011, 1'b0, 1'b0, IRO | MARI, RAMO | BIN, ALUO | AIN | FLG | SUBM);
        run_instr("add",  4'b0010, 1'b1, 1'b1, IRO | MARI, RAMO | BIN, ALUO | AIN | FLG);
        run_instr("lda",  4'b0001, 1'b0, 1'b0, IRO | MARI, RAMO | AIN, 15'd0);
        run_instr("sta",  4'b0100, 1'b0, 1'b0, IRO | MARI, AO | RAMI, 15'd0);
        run_instr("ldi",  4'b0101, 1'b0, 1'b0, IRO | AIN, 15'd0, 15'd0);
        run_instr("jmp",  4'b0110, 1'b0, 1'b0, IRO | PCJ, 15'd0, 15'd0);
        run_instr("jc0",  4'b0111, 1'b0, 1'b1, IRO, 15'd0, 15'd0);
        run_instr("jc1",  4'b0111, 1'b1, 1'b0, IRO | PCJ, 15'd0, 15'd0);
        run_instr("jz0",  4'b1000, 1'b1, 1'b0, IRO, 15'd0, 15'd0);
        run_instr("jz1",  4'b1000, 1'b0, 1'b1, IRO | PCJ, 15'd0, 15'd0);
        run_instr("out",  4'b1110, 1'b0, 1'b0, AO | OUTI, 15'd0, 15'd0);
        run_instr("undef", 4'b1011, 1'b1, 1'b1, 15'd0, 15'd0, 15'd0);

        // JC flag flips within s2 are seen immediately
        opcode = 4'b0111; carry_flag = 1'b0;
        nxt(); nxt();
        chk("jc_live0", {17'd0, strb}, {17'd0, IRO});
        carry_flag = 1'b1;
        #1;
        chk("jc_live1", {17'd0, strb}, {17'd0, IRO | PCJ});
        nxt(); nxt(); nxt();
        chk("jc_wrap", {29'd0, step}, 32'd0);

        // Async reset during LDA s3
        opcode = 4'b0001; carry_flag = 1'b0;
        nxt(); nxt(); nxt();
        chk("lda_s3_ain", {31'd0, a_in}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_step", {29'd0, step}, 32'd0);
        chk("arst_ain", {31'd0, a_in}, 32'd0);
        chk("arst_strb", {17'd0, strb}, {17'd0, PCO | MARI});
        @(negedge clk);
        rst = 1'b1;
        opcode = 4'b0000;
        nxt();
        chk("rel_step1", {29'd0, step}, 32'd1);
        nxt(); nxt(); nxt(); nxt();

        // Halt: freezes at step 3 with no strobes until reset
        opcode = 4'b1111;
        nxt(); nxt();
        chk("hlt_s2", {16'd0, halt, strb}, 32'd0);
        nxt();
        for (int i = 0; i < 20; i++) begin
            opcode = 4'(i);
            carry_flag = i[0]; zero_flag = i[1];
            #1;
            chk("hlt_hold", {13'd0, halt, step, strb}, {13'd0, 1'b1, 3'd3, 15'd0});
            nxt();
        end
        rst = 1'b0;
        #1;
        chk("hlt_rst", {28'd0, halt, step}, 32'd0);
        chk("hlt_rst_strb", {17'd0, strb}, {17'd0, PCO | MARI});

        // Random opcodes/flags (HLT excluded so the walk keeps going)
        @(negedge clk);
        rst = 1'b1;
        exp_step = 0;
        for (int i = 0; i < 1000; i++) begin
            opcode = 4'($urandom_range(0, 14));
            carry_flag = 1'($urandom);
            zero_flag = 1'($urandom);
            #1;
            nbus = int'(pc_out) + int'(ram_out) + int'(ir_out) + int'(a_out) + int'(alu_out);
            chk("rnd_step", {29'd0, step}, 32'(exp_step));
            chk("rnd_bus", 32'(nbus <= 1), 32'd1);
            chk("rnd_pcinc", {31'd0, pc_inc}, {31'd0, exp_step == 1});
            nxt();
            exp_step = (exp_step + 1) % 5;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
